// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and width default for the serial ALU
package alu_pkg;
  localparam int WIDTH = 32;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_NONE = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_e;
  function automatic logic inv_b(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction
endpackage

// File: rtl/alu_serial_slice.sv
// alu_serial_slice: combinational 1-bit ALU slice
// Ports: a, b (already inverted by caller for sub/slt), cin, op -> res, cout
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       res,
  output logic       cout
);
  logic w_sum;
  assign w_sum = a ^ b ^ cin;
  assign cout  = (a & b) | (a & cin) | (b & cin);
  assign res   = op == OP_AND ? a & b :
                 op == OP_OR  ? a | b :
                 op == OP_XOR ? a ^ b :
                 op == OP_NOR ? ~(a | b) :
                 op == OP_NONE ? 1'b0 : w_sum;
endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: sequences one 1-bit slice LSB-first to produce a WIDTH-bit ALU result
// Ports: clk, rst_n (async low); start_valid/start_ready with op, a, b;
//        done_valid/done_ready with result, zero; busy = not idle
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);
  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_carry, r_a_msb, r_b_msb, r_diff_msb, r_zero, r_done_valid;
  logic             w_b, w_res, w_cout, w_lt;
  assign w_b = inv_b(r_op) ? ~r_b_sh[0] : r_b_sh[0];
  // signed compare without overflow: differing signs decide directly
  assign w_lt = (r_a_msb ^ r_b_msb) ? r_a_msb : r_diff_msb;
  alu_serial_slice u_slice (
    .a   (r_a_sh[0]),
    .b   (w_b),
    .cin (r_carry),
    .op  (r_op),
    .res (w_res),
    .cout(w_cout)
  );
  assign result      = r_result;
  assign zero        = r_zero;
  assign done_valid  = r_done_valid;
  assign busy        = r_state != IDLE;
  assign start_ready = r_state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_result     <= '0;
      r_cnt        <= '0;
      r_op         <= '0;
      r_carry      <= 1'b0;
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_diff_msb   <= 1'b0;
      r_zero       <= 1'b0;
      r_done_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_valid) begin
          r_a_sh  <= a;
          r_b_sh  <= b;
          r_op    <= op;
          r_cnt   <= '0;
          r_carry <= inv_b(op);
          r_state <= RUN;
        end
        RUN: begin
          r_result <= {w_res, r_result[WIDTH-1:1]};
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_a_msb    <= r_a_sh[0];
            r_b_msb    <= r_b_sh[0];
            r_diff_msb <= w_res;
            r_state    <= r_op == OP_SLT ? SLT_FIX : DONE;
          end
        end
        SLT_FIX: begin
          r_result <= {{(WIDTH-1){1'b0}}, w_lt};
          r_state  <= DONE;
        end
        DONE: begin
          // done_valid rises one cycle after entering DONE; ready is only honoured once it is up
          if (r_done_valid && done_ready) begin
            r_done_valid <= 1'b0;
            r_zero       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_done_valid <= 1'b1;
            r_zero       <= ~|r_result;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
